pixel_unpacker: RTL and testbench

- Parametrised successor to the single-pixel RGB565 splitter.
- Accepts a byte stream from the UART/frame-buffer load path and assembles multi-byte pixels in one of three formats: RGB565, RGB555 and RGB888.
- Expands or truncates each channel to OUT_BITS and presents one pixel per valid/ready handshake to the frame-buffer writer.
- Adds resync, selectable byte order, selectable expansion rule and a pixel counter.

---
 rtl/pixel_fmt_pkg.sv | 39 +++
 rtl/channel_expand.sv | 26 ++
 rtl/pixel_unpacker.sv | 153 +++++++++++++++
 tb/tb_pixel_unpacker.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_fmt_pkg.sv
// Shared encodings for the pixel unpacker: input formats, pixel lengths and
// byte-index FSM states.
package pixel_fmt_pkg;

    localparam logic [1:0] MODE_RGB565 = 2'd0;
    localparam logic [1:0] MODE_RGB555 = 2'd1;
    localparam logic [1:0] MODE_RGB888 = 2'd2;

    localparam int BYTES_RGB16  = 2;
    localparam int BYTES_RGB888 = 3;

    typedef enum logic [1:0] {
        FMT_565 = 2'd0,
        FMT_555 = 2'd1,
        FMT_888 = 2'd2
    } fmt_t;

    typedef enum logic [1:0] {
        B0 = 2'd0,
        B1 = 2'd1,
        B2 = 2'd2
    } byte_idx_t;

    // The reserved encoding falls back to RGB565.
    function automatic fmt_t decode_mode(input logic [1:0] mode);
        case (mode)
            MODE_RGB555: return FMT_555;
            MODE_RGB888: return FMT_888;
            default:     return FMT_565;
        endcase
    endfunction

    function automatic byte_idx_t last_byte(input fmt_t fmt);
        if (fmt == FMT_888)
            return byte_idx_t'(2'(BYTES_RGB888 - 1));
        return byte_idx_t'(2'(BYTES_RGB16 - 1));
    endfunction

endpackage

// File: rtl/channel_expand.sv
// Widens or narrows one colour field to OUT_BITS. Purely combinational.
module channel_expand #(
    parameter int SRC_BITS   = 5,
    parameter int OUT_BITS   = 6,
    parameter int EXPAND_MSB = 0
) (
    input  logic [SRC_BITS-1:0] src,
    output logic [OUT_BITS-1:0] dst
);

    generate
        if (OUT_BITS <= SRC_BITS) begin : g_trunc
            assign dst = src[SRC_BITS-1 -: OUT_BITS];
        end else if (EXPAND_MSB == 0) begin : g_lsb_rep
            assign dst = {src, {(OUT_BITS - SRC_BITS){src[0]}}};
        end else begin : g_msb_rep
            // Source pattern repeated from the top, cut off at OUT_BITS.
            always_comb begin
                dst = '0;
                for (int i = 0; i < OUT_BITS; i++)
                    dst[OUT_BITS-1-i] = src[SRC_BITS-1-(i % SRC_BITS)];
            end
        end
    endgenerate

endmodule

// File: rtl/pixel_unpacker.sv
// Assembles RGB565/RGB555/RGB888 pixels from a byte stream and presents
// one registered pixel per valid/ready handshake.
//
// state | meaning
// B0    | waiting for byte 0 (format sampled here)
// B1    | byte 0 held; byte 1 completes 2-byte formats
// B2    | bytes 0,1 held; byte 2 completes RGB888
module pixel_unpacker
    import pixel_fmt_pkg::*;
#(
    parameter int OUT_BITS   = 6,
    parameter int BIG_ENDIAN = 1,
    parameter int EXPAND_MSB = 0,
    parameter int COUNT_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            mode,
    input  logic                  resync,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [OUT_BITS-1:0]   red,
    output logic [OUT_BITS-1:0]   green,
    output logic [OUT_BITS-1:0]   blue,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COUNT_BITS-1:0] pixel_count
);

    byte_idx_t state, state_next, pos;
    fmt_t      fmt_q, cur_fmt;
    logic      accept, complete, take;
    logic [7:0] byte0_q, byte1_q;

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= B0;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            if (complete)
                state_next = B0;
            else if (pos == B0)
                state_next = B1;
            else
                state_next = B2;
        end else if (resync) begin
            state_next = B0;
        end
    end

    // resync makes the current byte position 0 combinationally so that a
    // byte arriving alongside it is taken as byte 0.
    always_comb begin
        in_ready = !(out_valid && !out_ready);
        pos      = resync ? B0 : state;
        cur_fmt  = (pos == B0) ? decode_mode(mode) : fmt_q;
        accept   = in_valid && in_ready;
        complete = accept && (pos != B0) && (pos == last_byte(cur_fmt));
        take     = out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            byte0_q <= '0;
            byte1_q <= '0;
            fmt_q   <= FMT_565;
        end else if (accept) begin
            case (pos)
                B0: begin
                    byte0_q <= in_data;
                    byte1_q <= '0;
                    fmt_q   <= decode_mode(mode);
                end
                B1:      byte1_q <= in_data;
                default: ;
            endcase
        end else if (resync) begin
            byte0_q <= '0;
            byte1_q <= '0;
        end
    end

    logic [15:0] word;
    assign word = (BIG_ENDIAN != 0) ? {byte0_q, in_data} : {in_data, byte0_q};

    logic [OUT_BITS-1:0] r565, r555, g565, g555, b16, r888, g888, b888;

    channel_expand #(.SRC_BITS(5), .OUT_BITS(OUT_BITS), .EXPAND_MSB(EXPAND_MSB))
        u_r565 (.src(word[15:11]), .dst(r565));
    channel_expand #(.SRC_BITS(5), .OUT_BITS(OUT_BITS), .EXPAND_MSB(EXPAND_MSB))
        u_r555 (.src(word[14:10]), .dst(r555));
    channel_expand #(.SRC_BITS(6), .OUT_BITS(OUT_BITS), .EXPAND_MSB(EXPAND_MSB))
        u_g565 (.src(word[10:5]), .dst(g565));
    channel_expand #(.SRC_BITS(5), .OUT_BITS(OUT_BITS), .EXPAND_MSB(EXPAND_MSB))
        u_g555 (.src(word[9:5]), .dst(g555));
    channel_expand #(.SRC_BITS(5), .OUT_BITS(OUT_BITS), .EXPAND_MSB(EXPAND_MSB))
        u_b16 (.src(word[4:0]), .dst(b16));
    channel_expand #(.SRC_BITS(8), .OUT_BITS(OUT_BITS), .EXPAND_MSB(EXPAND_MSB))
        u_r888 (.src(byte0_q), .dst(r888));
    channel_expand #(.SRC_BITS(8), .OUT_BITS(OUT_BITS), .EXPAND_MSB(EXPAND_MSB))
        u_g888 (.src(byte1_q), .dst(g888));
    channel_expand #(.SRC_BITS(8), .OUT_BITS(OUT_BITS), .EXPAND_MSB(EXPAND_MSB))
        u_b888 (.src(in_data), .dst(b888));

    logic [OUT_BITS-1:0] red_next, green_next, blue_next;

    always_comb begin
        red_next   = r565;
        green_next = g565;
        blue_next  = b16;
        case (cur_fmt)
            FMT_555: begin
                red_next   = r555;
                green_next = g555;
            end
            FMT_888: begin
                red_next   = r888;
                green_next = g888;
                blue_next  = b888;
            end
            default: ;
        endcase
    end

    // A completion in the same cycle as a handshake replaces the old pixel.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            out_valid   <= 1'b0;
            pixel_count <= '0;
        end else begin
            if (complete) begin
                red       <= red_next;
                green     <= green_next;
                blue      <= blue_next;
                out_valid <= 1'b1;
            end else if (take) begin
                out_valid <= 1'b0;
            end
            if (take)
                pixel_count <= pixel_count + COUNT_BITS'(1);
        end
    end

endmodule

// File: tb/tb_pixel_unpacker.sv
// Directed bench for pixel_unpacker: four instances cover the default build,
// MSB-replicating expansion, little-endian byte order and a 2-bit counter.
module tb_pixel_unpacker;

   logic       clk = 1'b0;
   logic       reset_n, resync, in_valid, out_ready;
   logic [1:0] mode;
   logic [7:0] in_data;

   logic [5:0]  r0, g0, b0, r1, g1, b1, r2, g2, b2, r3, g3, b3;
   logic        ov0, ov1, ov2, ov3, ir0, ir1, ir2, ir3;
   logic [15:0] pc0, pc1, pc2;
   logic [1:0]  pc3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pixel_unpacker #(.OUT_BITS(6), .BIG_ENDIAN(1), .EXPAND_MSB(0), .COUNT_BITS(16)) d0 (
      .clk(clk), .reset_n(reset_n), .mode(mode), .resync(resync), .in_data(in_data),
      .in_valid(in_valid), .in_ready(ir0), .red(r0), .green(g0), .blue(b0),
      .out_valid(ov0), .out_ready(out_ready), .pixel_count(pc0));
   pixel_unpacker #(.OUT_BITS(6), .BIG_ENDIAN(1), .EXPAND_MSB(1), .COUNT_BITS(16)) d1 (
      .clk(clk), .reset_n(reset_n), .mode(mode), .resync(resync), .in_data(in_data),
      .in_valid(in_valid), .in_ready(ir1), .red(r1), .green(g1), .blue(b1),
      .out_valid(ov1), .out_ready(out_ready), .pixel_count(pc1));
   pixel_unpacker #(.OUT_BITS(6), .BIG_ENDIAN(0), .EXPAND_MSB(0), .COUNT_BITS(16)) d2 (
      .clk(clk), .reset_n(reset_n), .mode(mode), .resync(resync), .in_data(in_data),
      .in_valid(in_valid), .in_ready(ir2), .red(r2), .green(g2), .blue(b2),
      .out_valid(ov2), .out_ready(out_ready), .pixel_count(pc2));
   pixel_unpacker #(.OUT_BITS(6), .BIG_ENDIAN(1), .EXPAND_MSB(0), .COUNT_BITS(2)) d3 (
      .clk(clk), .reset_n(reset_n), .mode(mode), .resync(resync), .in_data(in_data),
      .in_valid(in_valid), .in_ready(ir3), .red(r3), .green(g3), .blue(b3),
      .out_valid(ov3), .out_ready(out_ready), .pixel_count(pc3));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      resync    = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      mode      = 2'd0;
      out_ready = 1'b1;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   // Presents one byte for one cycle; callers only use it while in_ready is high.
   task automatic push(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({ov0, ov1, ov2, ov3} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_out_valid: got %b expected 0000", {ov0, ov1, ov2, ov3});
      end
      n_checks++;
      if ({r0, g0, b0} !== 18'h0) begin
         n_fail++;
         $display("FAIL reset_rgb: got %h expected 00000", {r0, g0, b0});
      end
      n_checks++;
      if (pc0 !== 16'd0 || pc1 !== 16'd0 || pc2 !== 16'd0 || pc3 !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_count: got %0d/%0d/%0d/%0d expected 0", pc0, pc1, pc2, pc3);
      end
      n_checks++;
      if ({ir0, ir1, ir2, ir3} !== 4'b1111) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b expected 1111", {ir0, ir1, ir2, ir3});
      end
      n_checks++;
      if ({r1, g1, b1, r2, g2, b2, r3, g3, b3} !== 54'h0) begin
         n_fail++;
         $display("FAIL reset_rgb_variants: got %h expected 0", {r1, g1, b1, r2, g2, b2, r3, g3, b3});
      end
   endtask

   task automatic test_rgb565();
      do_reset();
      push(8'h80);
      n_checks++;
      if (ov0 !== 1'b0) begin
         n_fail++;
         $display("FAIL rgb565_early_valid: got %b expected 0", ov0);
      end
      push(8'h00);
      n_checks++;
      if (ov0 !== 1'b1 || {r0, g0, b0} !== {6'h20, 6'h00, 6'h00}) begin
         n_fail++;
         $display("FAIL rgb565_legacy: got v=%b %h expected v=1 %h", ov0, {r0, g0, b0}, {6'h20, 6'h00, 6'h00});
      end
      n_checks++;
      if (ov1 !== 1'b1 || {r1, g1, b1} !== {6'h21, 6'h00, 6'h00}) begin
         n_fail++;
         $display("FAIL rgb565_msb_rep: got v=%b %h expected v=1 %h", ov1, {r1, g1, b1}, {6'h21, 6'h00, 6'h00});
      end
      tick();
      n_checks++;
      if (ov0 !== 1'b0 || pc0 !== 16'd1) begin
         n_fail++;
         $display("FAIL rgb565_handshake: got v=%b count=%0d expected v=0 count=1", ov0, pc0);
      end
   endtask

   task automatic test_little_endian();
      do_reset();
      push(8'h00);
      push(8'h80);
      n_checks++;
      if (ov2 !== 1'b1 || {r2, g2, b2} !== {6'h20, 6'h00, 6'h00}) begin
         n_fail++;
         $display("FAIL little_endian: got v=%b %h expected v=1 %h", ov2, {r2, g2, b2}, {6'h20, 6'h00, 6'h00});
      end
      tick();
      n_checks++;
      if (pc2 !== 16'd1) begin
         n_fail++;
         $display("FAIL little_endian_count: got %0d expected 1", pc2);
      end
   endtask

   task automatic test_rgb888_mode_latch();
      do_reset();
      mode = 2'd2;
      push(8'hAB);
      mode = 2'd0;
      push(8'hCD);
      n_checks++;
      if (ov0 !== 1'b0) begin
         n_fail++;
         $display("FAIL rgb888_mode_latch: got out_valid %b after byte 1 expected 0", ov0);
      end
      push(8'hEF);
      n_checks++;
      if (ov0 !== 1'b1 || {r0, g0, b0} !== {6'h2A, 6'h33, 6'h3B}) begin
         n_fail++;
         $display("FAIL rgb888: got v=%b %h expected v=1 %h", ov0, {r0, g0, b0}, {6'h2A, 6'h33, 6'h3B});
      end
      n_checks++;
      if ({r1, g1, b1} !== {6'h2A, 6'h33, 6'h3B}) begin
         n_fail++;
         $display("FAIL rgb888_msb_rep: got %h expected %h", {r1, g1, b1}, {6'h2A, 6'h33, 6'h3B});
      end
      tick();
   endtask

   task automatic test_rgb555_back_to_back();
      do_reset();
      mode = 2'd1;
      push(8'h7F);
      push(8'hFF);
      n_checks++;
      if (ov0 !== 1'b1 || {r0, g0, b0} !== {6'h3F, 6'h3F, 6'h3F}) begin
         n_fail++;
         $display("FAIL rgb555_ones: got v=%b %h expected v=1 %h", ov0, {r0, g0, b0}, {6'h3F, 6'h3F, 6'h3F});
      end
      push(8'h80);
      n_checks++;
      if (ov0 !== 1'b0 || pc0 !== 16'd1) begin
         n_fail++;
         $display("FAIL rgb555_gap: got v=%b count=%0d expected v=0 count=1", ov0, pc0);
      end
      push(8'h00);
      n_checks++;
      if (ov0 !== 1'b1 || {r0, g0, b0} !== 18'h0) begin
         n_fail++;
         $display("FAIL rgb555_bit15_ignored: got v=%b %h expected v=1 00000", ov0, {r0, g0, b0});
      end
      tick();
      n_checks++;
      if (pc0 !== 16'd2) begin
         n_fail++;
         $display("FAIL rgb555_count: got %0d expected 2", pc0);
      end
   endtask

   task automatic test_resync();
      do_reset();
      mode = 2'd2;
      push(8'hAA);
      resync = 1'b1;
      mode   = 2'd0;
      push(8'h12);
      resync = 1'b0;
      n_checks++;
      if (ov0 !== 1'b0) begin
         n_fail++;
         $display("FAIL resync_early_valid: got %b expected 0", ov0);
      end
      push(8'h34);
      n_checks++;
      if (ov0 !== 1'b1 || {r0, g0, b0} !== {6'h04, 6'h11, 6'h28}) begin
         n_fail++;
         $display("FAIL resync_pixel: got v=%b %h expected v=1 %h", ov0, {r0, g0, b0}, {6'h04, 6'h11, 6'h28});
      end
      out_ready = 1'b0;
      resync    = 1'b1;
      tick();
      resync = 1'b0;
      n_checks++;
      if (ov0 !== 1'b1 || {r0, g0, b0} !== {6'h04, 6'h11, 6'h28} || pc0 !== 16'd0) begin
         n_fail++;
         $display("FAIL resync_hold: got v=%b %h count=%0d expected v=1 %h count=0",
                  ov0, {r0, g0, b0}, pc0, {6'h04, 6'h11, 6'h28});
      end
      out_ready = 1'b1;
      tick();
      n_checks++;
      if (ov0 !== 1'b0 || pc0 !== 16'd1) begin
         n_fail++;
         $display("FAIL resync_release: got v=%b count=%0d expected v=0 count=1", ov0, pc0);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0]  bytes [8];
      logic [17:0] exp_px [4];
      logic [17:0] seen [4];
      int acc, got, stall, cyc;
      logic will_acc, will_take;
      bytes  = '{8'h80, 8'h00, 8'hFF, 8'hFF, 8'h08, 8'h41, 8'hF8, 8'h1F};
      exp_px = '{{6'h20, 6'h00, 6'h00}, {6'h3F, 6'h3F, 6'h3F},
                 {6'h03, 6'h02, 6'h03}, {6'h3F, 6'h00, 6'h3F}};
      seen   = '{default: '0};
      acc = 0; got = 0; stall = 0; cyc = 0;
      do_reset();
      while (got < 4 && cyc < 80) begin
         in_valid  = (acc < 8);
         in_data   = (acc < 8) ? bytes[acc] : 8'h00;
         out_ready = !(ov0 && got == 0 && stall < 3);
         #1;
         if (!out_ready) begin
            stall++;
            n_checks++;
            if (ir0 !== 1'b0) begin
               n_fail++;
               $display("FAIL bp_in_ready_stall: got %b expected 0", ir0);
            end
         end
         will_acc  = in_valid && ir0;
         will_take = ov0 && out_ready;
         if (will_take) begin
            seen[got] = {r0, g0, b0};
            got++;
         end
         tick();
         cyc++;
         if (will_acc)
            acc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n_checks++;
      if (got !== 4) begin
         n_fail++;
         $display("FAIL bp_timeout: got %0d pixels expected 4", got);
      end
      n_checks++;
      if (stall !== 3 || acc !== 8) begin
         n_fail++;
         $display("FAIL bp_stall_bytes: got stall=%0d bytes=%0d expected stall=3 bytes=8", stall, acc);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (seen[i] !== exp_px[i]) begin
            n_fail++;
            $display("FAIL bp_pixel%0d: got %h expected %h", i, seen[i], exp_px[i]);
         end
      end
      n_checks++;
      if (pc0 !== 16'd4) begin
         n_fail++;
         $display("FAIL bp_count: got %0d expected 4", pc0);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      push(8'hFF);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      push(8'h80);
      push(8'h00);
      n_checks++;
      if (ov0 !== 1'b1 || {r0, g0, b0} !== {6'h20, 6'h00, 6'h00}) begin
         n_fail++;
         $display("FAIL reset_mid_fresh: got v=%b %h expected v=1 %h", ov0, {r0, g0, b0}, {6'h20, 6'h00, 6'h00});
      end
      out_ready = 1'b0;
      tick();
      n_checks++;
      if (ov0 !== 1'b1 || ir0 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_stall_setup: got v=%b in_ready=%b expected v=1 in_ready=0", ov0, ir0);
      end
      reset_n = 1'b0;
      tick();
      reset_n   = 1'b1;
      out_ready = 1'b1;
      n_checks++;
      if (ov0 !== 1'b0 || {r0, g0, b0} !== 18'h0 || pc0 !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_stalled: got v=%b %h count=%0d expected v=0 00000 count=0", ov0, {r0, g0, b0}, pc0);
      end
   endtask

   task automatic test_count_wrap();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         push(8'h12);
         push(8'h34);
      end
      tick();
      n_checks++;
      if (pc3 !== 2'd1) begin
         n_fail++;
         $display("FAIL count_wrap: got %0d expected 1", pc3);
      end
      n_checks++;
      if (pc0 !== 16'd5) begin
         n_fail++;
         $display("FAIL count_five: got %0d expected 5", pc0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_rgb565();
      test_little_endian();
      test_rgb888_mode_latch();
      test_rgb555_back_to_back();
      test_resync();
      test_backpressure();
      test_reset_mid();
      test_count_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
